// File: rtl/pu_layer_ctrl.sv
// pu_layer_ctrl: sequences one neural layer through a 4-input PU with a 2-stage result pipeline
module pu_layer_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int MAX_NEURONS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   neuron_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a1,
    input  logic [31:0]       in_a2,
    input  logic [31:0]       in_a3,
    input  logic [31:0]       in_a4,
    output logic [31:0]       a1,
    output logic [31:0]       a2,
    output logic [31:0]       a3,
    output logic [31:0]       a4,
    output logic [ADDR_W-1:0] w_addr,
    output logic              pu_issue,
    input  logic [31:0]       pu_out,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [31:0]       res_data,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_NEURONS);

    state_t            state, next;
    logic [ADDR_W:0]   cnt_max;
    logic [ADDR_W-1:0] k, w_hold, i1, i2;
    logic              v1, v2, last;

    assign last     = {1'b0, k} == cnt_max - 1'b1;
    assign res_we   = v2;
    assign res_addr = i2;
    assign res_data = pu_out;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // next-state and control outputs; DRAIN ends once stage 1 holds no valid neuron
    always_comb begin
        next     = state;
        in_ready = state == LOAD;
        pu_issue = state == ISSUE;
        busy     = state != IDLE;
        done     = state == DONE;
        w_addr   = state == ISSUE ? k : w_hold;
        case (state)
            IDLE:    next = start ? LOAD : IDLE;
            LOAD:    next = !in_valid ? LOAD : (cnt_max == '0 ? DONE : ISSUE);
            ISSUE:   next = last ? DRAIN : ISSUE;
            DRAIN:   next = v1 ? DRAIN : DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // datapath: layer size, activation latch, issue counter and valid/index pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_max <= '0;
            {a1, a2, a3, a4} <= '0;
            k       <= '0;
            w_hold  <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            i1      <= '0;
            i2      <= '0;
        end else begin
            if (state == IDLE && start)
                cnt_max <= neuron_count > MAX_CNT ? MAX_CNT : neuron_count;
            if (state == LOAD && in_valid) begin
                {a1, a2, a3, a4} <= {in_a1, in_a2, in_a3, in_a4};
                k <= '0;
            end
            if (state == ISSUE) begin
                w_hold <= k;
                if (!last) k <= k + 1'b1;
            end
            v1 <= state == ISSUE;
            i1 <= k;
            v2 <= v1;
            i2 <= i1;
        end
    end
endmodule

// File: tb/tb_pu_layer_ctrl.sv
// tb_pu_layer_ctrl: directed bench with a PU/ROM model and a write scoreboard
module tb_pu_layer_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [4:0]  neuron_count = '0;
    logic [31:0] in_a1 = '0, in_a2 = '0, in_a3 = '0, in_a4 = '0;
    logic [31:0] a1, a2, a3, a4, pu_out, res_data;
    logic [3:0]  w_addr, res_addr;
    logic        in_ready, pu_issue, res_we, busy, done;

    int checks = 0, errors = 0, cyc = 0;
    bit uni_w = 1'b1;
    logic [31:0] act [4] = '{0, 0, 0, 0};
    logic [31:0] s1 = 32'hdeadbeef, s2 = 32'hcafef00d;

    typedef struct { logic [3:0] addr; logic [31:0] data; int cyc; } exp_t;
    exp_t sb[$];

    pu_layer_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .neuron_count(neuron_count),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a1(in_a1), .in_a2(in_a2), .in_a3(in_a3), .in_a4(in_a4),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .w_addr(w_addr), .pu_issue(pu_issue),
        .pu_out(pu_out), .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] wt(input int addr, input int j);
        if (uni_w) return 32'd1;
        case (j)
            0:       return 32'(addr + 1);
            1:       return 32'(2 * addr + 3);
            2:       return 32'(17 - addr);
            default: return 32'(addr ^ 5);
        endcase
    endfunction

    function automatic logic [31:0] dot(input logic [31:0] x [4], input int addr);
        return x[0] * wt(addr, 0) + x[1] * wt(addr, 1) + x[2] * wt(addr, 2) + x[3] * wt(addr, 3);
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] v);
        return v[31] ? 32'd0 : v;
    endfunction

    // PU model: ROM read combinationally, multiply-accumulate register, then ReLU register (unreset)
    always @(posedge clk) begin
        s1 <= dot('{a1, a2, a3, a4}, int'(w_addr));
        s2 <= relu(s1);
    end
    assign pu_out = s2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every write must match the oldest outstanding issue in address, data and cycle
    always @(negedge clk) begin
        if (res_we) begin
            if (sb.size() == 0) chk("spurious_we", res_we, 1'b0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", res_addr, e.addr);
                chk("wr_data", res_data, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag);
        chk({tag, "_a1"}, a1, act[0]);
        chk({tag, "_a2"}, a2, act[1]);
        chk({tag, "_a3"}, a3, act[2]);
        chk({tag, "_a4"}, a4, act[3]);
    endtask

    task automatic layer(input int n, input int stall, input logic [31:0] x1, input logic [31:0] x2,
                         input logic [31:0] x3, input logic [31:0] x4, input bit uni,
                         input bit start_mid, input bit start_done);
        int nn;
        nn = n > 16 ? 16 : n;
        uni_w = uni;
        start = 1'b1;
        neuron_count = 5'(n);
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_ready", in_ready, 1'b0);
        tick();
        start = 1'b0;
        repeat (stall) begin
            @(negedge clk);
            chk("load_ready", in_ready, 1'b1);
            chk("load_busy", busy, 1'b1);
            chk("load_issue", pu_issue, 1'b0);
            chk_a("load_hold");
            tick();
        end
        in_valid = 1'b1;
        {in_a1, in_a2, in_a3, in_a4} = {x1, x2, x3, x4};
        @(negedge clk);
        chk("hs_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        {in_a1, in_a2, in_a3, in_a4} = {$urandom, $urandom, $urandom, $urandom};
        act = '{x1, x2, x3, x4};
        for (int i = 0; i < nn; i++) begin
            start = start_mid && i == 3;
            @(negedge clk);
            if (i == 0) chk_a("latched");
            chk("issue", pu_issue, 1'b1);
            chk("w_addr", w_addr, 64'(i));
            sb.push_back('{4'(i), relu(dot(act, i)), cyc + 2});
            tick();
        end
        start = 1'b0;
        if (nn > 0) repeat (2) begin
            @(negedge clk);
            chk("drain_issue", pu_issue, 1'b0);
            chk("drain_busy", busy, 1'b1);
            chk("drain_done", done, 1'b0);
            chk("w_hold", w_addr, 64'(nn - 1));
            tick();
        end
        @(negedge clk);
        chk("done", done, 1'b1);
        chk("done_busy", busy, 1'b1);
        chk("sb_empty", sb.size(), 0);
        chk_a("done_hold");
        start = start_done;
        tick();
        start = 1'b0;
        if (start_done) begin
            @(negedge clk);
            chk("start_at_done_ignored", busy, 1'b0);
            tick();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_issue", pu_issue, 1'b0);
        chk("rst_we", res_we, 1'b0);
        chk("rst_res_addr", res_addr, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk_a("rst");
        rst_n = 1'b1;
        tick();
        layer(3, 0, 1, 2, 3, 4, 1'b1, 1'b0, 1'b0);
        layer(3, 5, 1, 2, 3, 4, 1'b1, 1'b0, 1'b0);
        layer(4, 2, 9, -1, 3, 2, 1'b0, 1'b0, 1'b0);
        layer(0, 0, 7, 7, 7, 7, 1'b1, 1'b0, 1'b1);
        layer(16, 0, 5, -3, 7, 2, 1'b0, 1'b1, 1'b0);
        layer(20, 1, -8, 4, 1, 6, 1'b0, 1'b0, 1'b0);
        uni_w = 1'b1;
        start = 1'b1;
        neuron_count = 5'd5;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        {in_a1, in_a2, in_a3, in_a4} = {32'd3, 32'd3, 32'd3, 32'd3};
        tick();
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_test_issue", pu_issue, 1'b1);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_we", res_we, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_issue", pu_issue, 1'b0);
        chk("midrst_ready", in_ready, 1'b0);
        chk("midrst_w_addr", w_addr, 0);
        chk("midrst_res_addr", res_addr, 0);
        act = '{0, 0, 0, 0};
        chk_a("midrst");
        tick();
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 1'b0);
            chk("post_rst_we", res_we, 1'b0);
            tick();
        end
        layer(2, 0, 11, 0, -2, 1, 1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
